// File: rtl/key_debouncer_if.sv
// ============================================================================
// key_debouncer_if : raw key inputs and debounced level/pulse outputs. Rev 1.0
// ============================================================================
`default_nettype none

interface key_debouncer_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] KEY;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;

  // master owns the buttons and consumes the debounced events
  modport master (
    output KEY,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_repeat
  );

  modport slave (
    input  KEY,
    output key_level,
    output key_press,
    output key_release,
    output key_repeat
  );
endinterface

`default_nettype wire

// File: rtl/key_debouncer.sv
// ============================================================================
// key_debouncer : per-key sync, debounce, press/release/auto-repeat. Rev 1.0
// ============================================================================
`default_nettype none

module key_debouncer #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  wire logic          CLOCK_50,
  input  wire logic          reset,
  key_debouncer_if.slave     bus
);

  localparam int c_DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int c_RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_TW   = $clog2(c_RMAX);

  localparam logic [c_DW-1:0] c_DEB_LAST    = c_DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_TW-1:0] c_DELAY_LAST  = c_TW'(REPEAT_DELAY - 1);
  localparam logic [c_TW-1:0] c_PERIOD_LAST = c_TW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic [1:0]      r_sync;
    logic [c_DW-1:0] r_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            r_repeat;
    logic [1:0]      r_state;
    logic [c_TW-1:0] r_timer;

    logic            w_disagree;
    logic            w_settle;
    logic            w_press_evt;
    logic            w_release_evt;
    logic [1:0]      w_state_nxt;
    logic [c_TW-1:0] w_timer_nxt;
    logic            w_repeat_nxt;

    assign w_disagree    = r_sync[1] != r_level;
    assign w_settle      = w_disagree && (r_cnt == c_DEB_LAST);
    assign w_press_evt   = w_settle && r_sync[1];
    assign w_release_evt = w_settle && !r_sync[1];

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        r_sync    <= 2'b00;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_sync <= {r_sync[0], ~bus.KEY[i]};
        if (!w_disagree || w_settle) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_DW'(1);
        end
        if (w_settle) begin
          r_level <= r_sync[1];
        end
        r_press   <= w_press_evt;
        r_release <= w_release_evt;
      end
    end

    // The FSM follows the debounce events rather than the registered pulses,
    // so the registered repeat lands exactly REPEAT_DELAY after key_press.
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        r_state  <= ST_IDLE;
        r_timer  <= '0;
        r_repeat <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_timer  <= w_timer_nxt;
        r_repeat <= w_repeat_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      case (r_state)
        ST_IDLE: begin
          if (w_press_evt) begin
            w_state_nxt = ST_HOLD;
            w_timer_nxt = '0;
          end
        end
        ST_HOLD: begin
          if (w_release_evt) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
          end else if (r_timer == c_DELAY_LAST) begin
            w_state_nxt = ST_REPEAT;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + c_TW'(1);
          end
        end
        ST_REPEAT: begin
          if (w_release_evt) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
          end else if (r_timer == c_PERIOD_LAST) begin
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + c_TW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end

    // A repeat falling due on the release edge is dropped.
    always_comb begin
      w_repeat_nxt = 1'b0;
      if (!w_release_evt) begin
        if (r_state == ST_HOLD && r_timer == c_DELAY_LAST) begin
          w_repeat_nxt = 1'b1;
        end else if (r_state == ST_REPEAT && r_timer == c_PERIOD_LAST) begin
          w_repeat_nxt = 1'b1;
        end
      end
    end

    assign bus.key_level[i]   = r_level;
    assign bus.key_press[i]   = r_press;
    assign bus.key_release[i] = r_release;
    assign bus.key_repeat[i]  = r_repeat;
  end

endmodule

`default_nettype wire

// File: tb/tb_key_debouncer.sv
// ============================================================================
// tb_key_debouncer : directed self-checking bench for key_debouncer. Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_debouncer;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  key_debouncer_if #(.N_KEYS(4)) bus ();

  key_debouncer #(
    .N_KEYS          (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.KEY = 4'hF;
    repeat (3) tick();
    n_cmp++; if (bus.key_level !== 4'b0000) begin n_bad++; $display("FAIL reset_level: got %b want 0000", bus.key_level); end
    n_cmp++; if (bus.key_press !== 4'b0000) begin n_bad++; $display("FAIL reset_press: got %b want 0000", bus.key_press); end
    n_cmp++; if (bus.key_release !== 4'b0000) begin n_bad++; $display("FAIL reset_release: got %b want 0000", bus.key_release); end
    n_cmp++; if (bus.key_repeat !== 4'b0000) begin n_bad++; $display("FAIL reset_repeat: got %b want 0000", bus.key_repeat); end
    reset = 1'b0;
    repeat (3) tick();
  endtask

  // Key 0: KEY sampled low at edge 1 -> press at 6; repeats at 16,19,..,31;
  // released so its release lands at 34 where a repeat would have been due.
  task automatic test_press_repeat();
    int press_cnt = 0, press_at = -1, rise_at = -1, rel_cnt = 0, rel_at = -1;
    int other = 0, lvl_err = 0;
    int rep_q[$];
    bus.KEY[0] = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (bus.key_press[0]) begin press_cnt++; press_at = k; end
      if (bus.key_level[0] && rise_at < 0) rise_at = k;
      if (k >= 6 && k <= 33 && bus.key_level[0] !== 1'b1) lvl_err++;
      if (bus.key_repeat[0]) rep_q.push_back(k);
      if (bus.key_release[0]) begin rel_cnt++; rel_at = k; end
      if ((bus.key_press[3:1] | bus.key_release[3:1] | bus.key_repeat[3:1]) != 3'b000) other++;
      if (k == 28) bus.KEY[0] = 1'b1;
    end
    n_cmp++; if (rise_at !== 6) begin n_bad++; $display("FAIL press_level_latency: got %0d want 6", rise_at); end
    n_cmp++; if (press_at !== 6) begin n_bad++; $display("FAIL press_latency: got %0d want 6", press_at); end
    n_cmp++; if (press_cnt !== 1) begin n_bad++; $display("FAIL press_count: got %0d want 1", press_cnt); end
    n_cmp++; if (lvl_err !== 0) begin n_bad++; $display("FAIL level_held: got %0d drops want 0", lvl_err); end
    n_cmp++; if (rep_q.size() !== 6) begin n_bad++; $display("FAIL repeat_count: got %0d want 6", rep_q.size()); end
    for (int j = 0; j < rep_q.size(); j++) begin
      n_cmp++; if (rep_q[j] !== 16 + 3 * j) begin n_bad++; $display("FAIL repeat_time[%0d]: got %0d want %0d", j, rep_q[j], 16 + 3 * j); end
    end
    n_cmp++; if (rel_at !== 34) begin n_bad++; $display("FAIL release_latency: got %0d want 34", rel_at); end
    n_cmp++; if (rel_cnt !== 1) begin n_bad++; $display("FAIL release_count: got %0d want 1", rel_cnt); end
    n_cmp++; if (other !== 0) begin n_bad++; $display("FAIL press_other_keys: got %0d want 0", other); end
    n_cmp++; if (bus.key_level[0] !== 1'b0) begin n_bad++; $display("FAIL release_level: got %b want 0", bus.key_level[0]); end
  endtask

  // Key 1: samples 0,1,0,1 then stable 0 from edge 5 -> press at 10.
  task automatic test_bounce();
    logic [3:0] bounce = 4'b1010;
    int press_cnt = 0, press_at = -1, rel_at = -1, rep_cnt = 0, early_lvl = 0;
    for (int k = 1; k <= 24; k++) begin
      if (k <= 4) bus.KEY[1] = bounce[k-1];
      else if (k <= 14) bus.KEY[1] = 1'b0;
      else bus.KEY[1] = 1'b1;
      tick();
      if (bus.key_press[1]) begin press_cnt++; press_at = k; end
      if (k < 10 && bus.key_level[1] !== 1'b0) early_lvl++;
      if (bus.key_release[1]) rel_at = k;
      if (bus.key_repeat[1]) rep_cnt++;
    end
    n_cmp++; if (press_at !== 10) begin n_bad++; $display("FAIL bounce_press_time: got %0d want 10", press_at); end
    n_cmp++; if (press_cnt !== 1) begin n_bad++; $display("FAIL bounce_press_count: got %0d want 1", press_cnt); end
    n_cmp++; if (early_lvl !== 0) begin n_bad++; $display("FAIL bounce_early_level: got %0d want 0", early_lvl); end
    n_cmp++; if (rel_at !== 20) begin n_bad++; $display("FAIL bounce_release_time: got %0d want 20", rel_at); end
    n_cmp++; if (rep_cnt !== 0) begin n_bad++; $display("FAIL bounce_repeat_suppressed: got %0d want 0", rep_cnt); end
  endtask

  // Key 2: low for only 3 samples -> never accepted.
  task automatic test_glitch();
    int events = 0, lvl = 0;
    for (int k = 1; k <= 12; k++) begin
      bus.KEY[2] = (k <= 3) ? 1'b0 : 1'b1;
      tick();
      if ((bus.key_press | bus.key_release | bus.key_repeat) != 4'b0000) events++;
      if (bus.key_level[2] !== 1'b0) lvl++;
    end
    n_cmp++; if (events !== 0) begin n_bad++; $display("FAIL glitch_pulses: got %0d want 0", events); end
    n_cmp++; if (lvl !== 0) begin n_bad++; $display("FAIL glitch_level: got %0d want 0", lvl); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] press6 = 4'b0000, rel14 = 4'b0000, rep16 = 4'b0000;
    int press_bits = 0, rel_bits = 0, early_rep = 0;
    bus.KEY = 4'b0000;
    for (int k = 1; k <= 16; k++) begin
      if (k == 9) bus.KEY[1] = 1'b1;
      tick();
      press_bits += $countones(bus.key_press);
      if (k >= 9) rel_bits += $countones(bus.key_release);
      if (k == 6) press6 = bus.key_press;
      if (k == 14) rel14 = bus.key_release;
      if (k == 16) rep16 = bus.key_repeat;
      else if (bus.key_repeat != 4'b0000) early_rep++;
    end
    n_cmp++; if (press6 !== 4'b1111) begin n_bad++; $display("FAIL simul_press: got %b want 1111", press6); end
    n_cmp++; if (press_bits !== 4) begin n_bad++; $display("FAIL simul_press_bits: got %0d want 4", press_bits); end
    n_cmp++; if (rel14 !== 4'b0010) begin n_bad++; $display("FAIL simul_release: got %b want 0010", rel14); end
    n_cmp++; if (rel_bits !== 1) begin n_bad++; $display("FAIL simul_release_bits: got %0d want 1", rel_bits); end
    n_cmp++; if (rep16 !== 4'b1101) begin n_bad++; $display("FAIL simul_first_repeat: got %b want 1101", rep16); end
    n_cmp++; if (early_rep !== 0) begin n_bad++; $display("FAIL simul_early_repeat: got %0d want 0", early_rep); end
  endtask

  // Keys 0,2,3 are held in REPEAT here; reset for two edges, then re-press.
  task automatic test_reset_held();
    logic [3:0] press6 = 4'b0000;
    logic [15:0] after_rst;
    int rel_bits = 0, press_at = -1;
    reset = 1'b1;
    tick();
    after_rst = {bus.key_level, bus.key_press, bus.key_release, bus.key_repeat};
    n_cmp++; if (after_rst !== 16'h0000) begin n_bad++; $display("FAIL reset_held_outputs: got %h want 0000", after_rst); end
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      rel_bits += $countones(bus.key_release);
      if (bus.key_press[0] && press_at < 0) press_at = k;
      if (k == 6) press6 = bus.key_press;
    end
    n_cmp++; if (press_at !== 6) begin n_bad++; $display("FAIL reset_repress_time: got %0d want 6", press_at); end
    n_cmp++; if (press6 !== 4'b1101) begin n_bad++; $display("FAIL reset_repress_keys: got %b want 1101", press6); end
    n_cmp++; if (rel_bits !== 0) begin n_bad++; $display("FAIL reset_no_release: got %0d want 0", rel_bits); end
  endtask

  initial begin
    bus.KEY = 4'hF;
    test_reset();
    test_press_repeat();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got no summary want summary");
    $fatal(1);
  end

endmodule

`default_nettype wire
